// File: rtl/run_control_pkg.sv
// rtl/run_control_pkg.sv - command and state encodings shared by the run controller
package run_control_pkg;

  typedef enum logic [1:0] {
    CMD_HALT = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_PROG = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_PROG,
    ST_PROG_EXIT
  } state_e;

endpackage

// File: rtl/run_control_tick_divider.sv
// rtl/run_control_tick_divider.sv - rate divider producing the "core_ce due" pulse
module tick_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             en,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a rate lowered mid-run cannot strand the counter
  assign tick = en && (cnt >= rate);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/run_control.sv
// rtl/run_control.sv - halt/run/step/program controller for a soft core
module run_control
  import run_control_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 24,
  localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_arg,
  input  logic [DIV_W-1:0]         rate,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic                     core_ce,
  output logic                     core_rst,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     halted,
  output logic                     bp_hit,
  output logic [BP_IDX_W-1:0]      bp_idx,
  output logic [CNT_W-1:0]         cycle_count
);

  state_e               state, state_next;
  cmd_op_e              op;
  logic                 accept, active, restart, tick, bp_stop, skip;
  logic                 bp_match;
  logic [BP_IDX_W-1:0]  match_idx;
  logic [CNT_W-1:0]     steps_left;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .en      (active),
    .rate    (rate),
    .tick    (tick)
  );

  // Scan downward so the lowest matching index is the one left standing
  always_comb begin
    bp_match  = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i*ADDR_W +: ADDR_W] == pc)) begin
        bp_match  = 1'b1;
        match_idx = BP_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HALT;
    else     state <= state_next;
  end

  always_comb begin
    op         = cmd_op_e'(cmd_op);
    cmd_ready  = (state != ST_PROG_EXIT);
    halted     = (state == ST_HALT);
    active     = (state == ST_RUN) || (state == ST_STEP);
    accept     = cmd_valid && cmd_ready;
    restart    = accept && ((op == CMD_RUN) || (op == CMD_STEP));
    state_next = state;
    core_ce    = 1'b0;
    bp_stop    = 1'b0;
    if (state == ST_PROG_EXIT) begin
      state_next = ST_HALT;
    end else if (accept) begin
      // A command always beats a pending pulse in the same cycle
      case (op)
        CMD_HALT: state_next = (state == ST_PROG) ? ST_PROG_EXIT : ST_HALT;
        CMD_RUN:  state_next = ST_RUN;
        CMD_STEP: state_next = (cmd_arg == '0) ? ST_HALT : ST_STEP;
        CMD_PROG: state_next = ST_PROG;
      endcase
    end else if (active && tick) begin
      if (bp_match && !skip) begin
        state_next = ST_HALT;
        bp_stop    = 1'b1;
      end else begin
        core_ce = 1'b1;
        if ((state == ST_STEP) && (steps_left == CNT_W'(1))) state_next = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst    <= 1'b1;
      skip        <= 1'b0;
      steps_left  <= '0;
      bp_hit      <= 1'b0;
      bp_idx      <= '0;
      cycle_count <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      core_rst <= (state_next == ST_PROG) || (state_next == ST_PROG_EXIT);

      // Lets execution resume from the very address that stopped it
      if (restart)              skip <= 1'b1;
      else if (active && tick)  skip <= 1'b0;

      if (accept && (op == CMD_STEP))      steps_left <= cmd_arg;
      else if (core_ce && (state == ST_STEP)) steps_left <= steps_left - CNT_W'(1);

      if (accept && (op != CMD_HALT)) begin
        bp_hit <= 1'b0;
      end else if (bp_stop) begin
        bp_hit <= 1'b1;
        bp_idx <= match_idx;
      end

      if (accept && (op == CMD_PROG))           cycle_count <= '0;
      else if (core_ce && (cycle_count != '1))  cycle_count <= cycle_count + CNT_W'(1);

      mem_we <= (state == ST_PROG) && prog_we;
      if (state == ST_PROG) begin
        mem_addr  <= prog_addr;
        mem_wdata <= prog_data;
      end
    end
  end

endmodule

// File: tb/tb_run_control.sv
// tb/tb_run_control.sv - randomized directed bench for run_control with arithmetic reference
module tb_run_control;
  localparam int ADDR_W = 8, DATA_W = 8, NUM_BP = 4, CNT_W = 8, DIV_W = 24;
  localparam logic [1:0] OP_HALT = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_PROG = 2'd3;
  localparam int CC_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic [DIV_W-1:0] rate;
  logic [ADDR_W-1:0] pc;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0] bp_en;
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr, mem_addr;
  logic [DATA_W-1:0] prog_data, mem_wdata;
  logic core_ce, core_rst, mem_we, halted, bp_hit;
  logic [1:0] bp_idx;
  logic [CNT_W-1:0] cycle_count;

  int tests = 0, fails = 0;
  int cc_model = 0;
  logic ce_seen [0:63];
  int halt_at;

  always #5 clk = ~clk;

  run_control #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .rate(rate), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .core_ce(core_ce),
    .core_rst(core_rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .halted(halted), .bp_hit(bp_hit), .bp_idx(bp_idx), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > CC_MAX) ? CC_MAX : v;
  endfunction

  // Issue one command in the current cycle; an accepted command never coincides with core_ce
  task automatic send(input logic [1:0] op, input int arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = CNT_W'(arg);
    #3;
    chk("cmd_ready", cmd_ready, 1);
    chk("cmd_ce_suppressed", core_ce, 0);
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  // Record core_ce per cycle after a command; the bench acts as the core and advances pc
  task automatic watch(input int n);
    halt_at = 0;
    for (int k = 1; k <= n; k++) begin
      #3;
      ce_seen[k] = core_ce;
      if (halted && halt_at == 0) halt_at = k;
      next_cycle();
      if (ce_seen[k]) pc = pc + 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r, n, s, j, ces, idx;
    int off [0:3];
    logic we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    cmd_valid = 0; cmd_op = 0; cmd_arg = 0; rate = 0; pc = 0;
    bp_addr = '0; bp_en = '0; prog_we = 0; prog_addr = 0; prog_data = 0;

    // reset values
    repeat (2) @(posedge clk);
    #4;
    chk("rst_core_ce", core_ce, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_halted", halted, 1);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    #3;
    chk("post_rst_halted", halted, 1);
    chk("post_rst_core_rst", core_rst, 0);
    chk("post_rst_mem_addr", mem_addr, 0);
    next_cycle();

    // RUN at rate 2: pulses on every third cycle
    rate = 2;
    send(OP_RUN, 0);
    watch(9);
    for (int k = 1; k <= 9; k++) chk("run3_ce", ce_seen[k], (k % 3 == 0));
    cc_model = sat(cc_model + 3);
    chk("run3_cycle_count", cycle_count, cc_model);
    send(OP_HALT, 0);
    #3; chk("run3_halted", halted, 1); next_cycle();

    // Random RUN lengths/rates; the closing HALT often lands on a due pulse
    for (int t = 0; t < 4; t++) begin
      r = $urandom_range(0, 3);
      n = $urandom_range(4, 12);
      rate = DIV_W'(r);
      send(OP_RUN, 0);
      watch(n);
      for (int k = 1; k <= n; k++) chk("run_ce", ce_seen[k], (k % (r + 1) == 0));
      chk("run_not_halted", halt_at, 0);
      cc_model = sat(cc_model + n / (r + 1));
      chk("run_cycle_count", cycle_count, cc_model);
      send(OP_HALT, 0);
      #3; chk("run_halted", halted, 1); next_cycle();
    end

    // STEP: 5 at rate 0, 0 steps, then random
    for (int t = 0; t < 5; t++) begin
      s = (t == 0) ? 5 : (t == 1) ? 0 : $urandom_range(1, 5);
      r = (t == 0) ? 0 : $urandom_range(0, 3);
      rate = DIV_W'(r);
      send(OP_STEP, s);
      watch(s * (r + 1) + 3);
      for (int k = 1; k <= s * (r + 1) + 3; k++)
        chk("step_ce", ce_seen[k], (k % (r + 1) == 0) && (k <= s * (r + 1)));
      chk("step_halt_at", halt_at, (s == 0) ? 1 : s * (r + 1) + 1);
      cc_model = sat(cc_model + s);
      chk("step_cycle_count", cycle_count, cc_model);
      next_cycle();
    end

    // Breakpoint at 0x10 on entries 1 and 2 (entry 0 disabled)
    rate = 0;
    pc = 8'h0C;
    bp_addr = {8'h30, 8'h10, 8'h10, 8'h10};
    bp_en = 4'b0110;
    send(OP_RUN, 0);
    watch(8);
    ces = 0;
    for (int k = 1; k <= 8; k++) ces += ce_seen[k];
    chk("bp_ce_count", ces, 4);
    chk("bp_halt_at", halt_at, 6);
    chk("bp_pc", pc, 8'h10);
    chk("bp_hit", bp_hit, 1);
    chk("bp_idx", bp_idx, 1);
    cc_model = sat(cc_model + 4);
    send(OP_RUN, 0);
    watch(3);
    for (int k = 1; k <= 3; k++) chk("bp_resume_ce", ce_seen[k], 1);
    chk("bp_hit_cleared", bp_hit, 0);
    cc_model = sat(cc_model + 3);
    send(OP_HALT, 0);
    next_cycle();

    // Random breakpoint sets: nearest enabled address wins, lowest index on ties
    for (int t = 0; t < 3; t++) begin
      pc = ADDR_W'($urandom_range(0, 200));
      bp_en = NUM_BP'($urandom_range(0, 15)) | NUM_BP'(1 << $urandom_range(0, 3));
      for (int i = 0; i < NUM_BP; i++) begin
        off[i] = $urandom_range(1, 10);
        bp_addr[i*ADDR_W +: ADDR_W] = pc + ADDR_W'(off[i]);
      end
      j = 99; idx = 0;
      for (int i = NUM_BP - 1; i >= 0; i--)
        if (bp_en[i] && off[i] <= j) begin j = off[i]; idx = i; end
      send(OP_RUN, 0);
      watch(j + 4);
      ces = 0;
      for (int k = 1; k <= j + 4; k++) ces += ce_seen[k];
      chk("rbp_ce_count", ces, j);
      chk("rbp_halt_at", halt_at, j + 2);
      chk("rbp_hit", bp_hit, 1);
      chk("rbp_idx", bp_idx, idx);
      cc_model = sat(cc_model + j);
      next_cycle();
    end
    bp_en = '0;
    chk("cc_before_prog", cycle_count, cc_model);

    // prog_* ignored outside PROG
    prog_we = 1; prog_addr = 8'h44; prog_data = 8'h5A;
    next_cycle();
    chk("halt_mem_we", mem_we, 0);
    prog_we = 0;

    // Programming session
    send(OP_PROG, 0);
    cc_model = 0;
    #3;
    chk("prog_cycle_count", cycle_count, 0);
    chk("prog_core_rst", core_rst, 1);
    chk("prog_halted", halted, 0);
    next_cycle();
    for (int w = 0; w < 5; w++) begin
      we = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = (w == 0) ? 8'h03 : ADDR_W'($urandom);
      d  = (w == 0) ? 8'hA5 : DATA_W'($urandom);
      prog_we = we; prog_addr = a; prog_data = d;
      next_cycle();
      chk("prog_mem_we", mem_we, we);
      chk("prog_mem_addr", mem_addr, a);
      chk("prog_mem_wdata", mem_wdata, d);
      chk("prog_core_rst_hold", core_rst, 1);
    end
    prog_we = 0;
    send(OP_HALT, 0);
    cmd_valid = 1; cmd_op = OP_RUN;
    #3;
    chk("exit_cmd_ready", cmd_ready, 0);
    chk("exit_core_rst", core_rst, 1);
    chk("exit_halted", halted, 0);
    next_cycle();
    cmd_valid = 0;
    #3;
    chk("exit_done_halted", halted, 1);
    chk("exit_done_core_rst", core_rst, 0);
    next_cycle();

    // cycle_count saturation
    rate = 0;
    send(OP_RUN, 0);
    repeat (CC_MAX + 6) next_cycle();
    #3;
    chk("sat_cycle_count", cycle_count, CC_MAX);
    chk("sat_core_ce", core_ce, 1);
    next_cycle();
    send(OP_HALT, 0);

    // Reset mid-RUN at rate 0
    send(OP_RUN, 0);
    watch(3);
    rst = 1;
    #1;
    chk("midrst_core_ce", core_ce, 0);
    chk("midrst_cycle_count", cycle_count, 0);
    chk("midrst_core_rst", core_rst, 1);
    next_cycle();
    #3; chk("midrst_hold_core_ce", core_ce, 0);
    next_cycle();
    rst = 0;
    next_cycle();
    #3;
    chk("midrst_halted", halted, 1);
    chk("midrst_core_rst_low", core_rst, 0);
    chk("midrst_cc_after", cycle_count, 0);
    next_cycle();

    // Reset mid-PROG with a write pending
    send(OP_PROG, 0);
    prog_we = 1;
    rst = 1;
    #3; chk("progrst_mem_we", mem_we, 0);
    next_cycle();
    chk("progrst_mem_we_hold", mem_we, 0);
    prog_we = 0;
    rst = 0;
    next_cycle();
    #3;
    chk("progrst_halted", halted, 1);
    chk("progrst_mem_addr", mem_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
- REQ-001 SHALL have parameter ADDR_W, 8, width of the core PC and the memory address.
- REQ-002 SHALL have parameter DATA_W, 8, width of the memory data.
- REQ-003 SHALL have parameter NUM_BP, 4, number of PC breakpoints (1..16).
- REQ-004 SHALL have parameter CNT_W, 16, width of the step argument and the cycle counter.
- REQ-005 SHALL have parameter DIV_W, 24, width of the run-rate divider.
- REQ-006 SHALL have port clk, input, 1, the single clock for all logic.
- REQ-007 SHALL have port rst, input, 1, reset: asynchronous, active-high.
- REQ-008 SHALL have port cmd_valid, input, 1, command strobe.
- REQ-009 SHALL have port cmd_ready, output, 1, command accepted when high together with cmd_valid.
- REQ-010 SHALL have port cmd_op, input, 2, command: 0 HALT, 1 RUN, 2 STEP, 3 PROG.
- REQ-011 SHALL have port cmd_arg, input, CNT_W, step count for the STEP command.
- REQ-012 SHALL have port rate, input, DIV_W, number of idle clk cycles between core_ce pulses.
- REQ-013 SHALL have port pc, input, ADDR_W, the current core program counter.
- REQ-014 SHALL have port bp_addr, input, NUM_BP*ADDR_W, breakpoint addresses, with entry i at bits [i*ADDR_W +: ADDR_W].
- REQ-015 SHALL have port bp_en, input, NUM_BP, per-breakpoint enable.
- REQ-016 SHALL have port prog_we, input, 1, programming write strobe.
- REQ-017 SHALL have port prog_addr, input, ADDR_W, programming write address.
- REQ-018 SHALL have port prog_data, input, DATA_W, programming write data.
- REQ-019 SHALL have port core_ce, output, 1, one-clk core clock-enable pulse.
- REQ-020 SHALL have port core_rst, output, 1, core reset.
- REQ-021 SHALL have port mem_we, mem_addr, mem_wdata, output, 1/ADDR_W/DATA_W, registered memory write port.
- REQ-022 SHALL have port halted, output, 1, high when the FSM is in HALT.
- REQ-023 SHALL have port bp_hit, output, 1, sticky flag: the last halt was caused by a breakpoint.
- REQ-024 SHALL have port bp_idx, output, $clog2(NUM_BP) (minimum 1), index of the breakpoint that hit.
- REQ-025 SHALL have port cycle_count, output, CNT_W, number of core_ce pulses issued.

Function
- REQ-026 SHALL implement FSM states HALT, RUN, STEP, PROG, PROG_EXIT.
- REQ-027 SHALL drive cmd_ready=1 in every state except PROG_EXIT.
- REQ-028 A HALT command SHALL move any state except PROG to HALT on the next clk; in PROG it SHALL move to PROG_EXIT.
- REQ-029 A RUN command SHALL enter RUN; a STEP command SHALL load the remaining-step counter with cmd_arg and enter STEP.
- REQ-030 STEP with cmd_arg=0 SHALL go to HALT without issuing core_ce.
- REQ-031 A PROG command SHALL enter PROG from any state and clear cycle_count.
- REQ-032 PROG_EXIT SHALL last exactly 1 clk and then go to HALT.
- REQ-033 In RUN and STEP, the divider SHALL pulse core_ce for 1 clk every rate+1 clk cycles; rate=0 SHALL give core_ce every cycle.
- REQ-034 The divider SHALL restart from 0 on entry to RUN or STEP.
- REQ-035 In STEP, each core_ce SHALL decrement the remaining-step counter; the core_ce that brings it to 0 SHALL be followed by HALT on the next clk.
- REQ-036 When a core_ce is due and pc equals an enabled bp_addr entry, core_ce SHALL be suppressed, the FSM SHALL go to HALT, bp_hit SHALL be set to 1, and bp_idx SHALL take the lowest matching index.
- REQ-037 The first due core_ce after a RUN or STEP command SHALL ignore breakpoints (skip flag), so execution can resume from a breakpoint address.
- REQ-038 Any accepted RUN, STEP or PROG command SHALL clear bp_hit.
- REQ-039 A command accepted in the same cycle as a due core_ce SHALL win: that core_ce is suppressed.
- REQ-040 cycle_count SHALL increment on each core_ce and saturate at 2^CNT_W-1.
- REQ-041 core_rst SHALL be 1 in PROG and PROG_EXIT and 0 elsewhere; core_ce SHALL be 0 outside RUN and STEP.
- REQ-042 In PROG, mem_we, mem_addr and mem_wdata SHALL register prog_we, prog_addr and prog_data with 1-clk latency.
- REQ-043 Outside PROG, mem_we SHALL be 0 and prog_* SHALL be ignored.

Reset
- REQ-044 While rst=1, the block SHALL force state HALT, core_ce=0, core_rst=1, mem_we=0, mem_addr=0, mem_wdata=0, bp_hit=0, bp_idx=0, cycle_count=0, divider=0, step counter=0, skip flag=0.
- REQ-045 After rst deasserts, the block SHALL output halted=1 and core_rst=0.
- REQ-046 Reset mid-operation (RUN, STEP or PROG) SHALL abort to the REQ-044 values with no further core_ce or mem_we.

Structure
- REQ-047 Package run_control_pkg SHALL hold the cmd_op enum (CMD_HALT, CMD_RUN, CMD_STEP, CMD_PROG) and the state enum.
- REQ-048 Sub-module tick_divider (parameter DIV_W; ports clk, rst, restart, en, rate, tick) SHALL generate the due-pulse.

Verification
- REQ-049 Reset, then RUN with rate=2 -> core_ce every 3rd clk and cycle_count=3 after 9 clk.
- REQ-050 STEP with cmd_arg=5, rate=0 -> exactly 5 consecutive core_ce, then halted=1 on the clk after the last pulse.
- REQ-051 bp_en=4'b0110, bp_addr[1]=bp_addr[2]=0x10, RUN until pc=0x10 -> no core_ce at 0x10, halted=1, bp_hit=1, bp_idx=1; then RUN -> one core_ce issued at pc=0x10.
- REQ-052 PROG, then prog_we=1, addr=0x3, data=0xA5 -> mem_we=1, mem_addr=0x3, mem_wdata=0xA5 one clk later, core_rst=1; then HALT -> cmd_ready=0 for 1 clk, then halted=1 and core_rst=0.
- REQ-053 rst asserted during RUN with rate=0 -> core_ce=0 in the same cycle, cycle_count=0, halted=1 after release.
